// File: rtl/instr_encoder.sv
// Packs instruction-class codes and register/immediate fields into 32-bit MIPS words
// and streams them into instruction memory at consecutive word addresses.
module instr_encoder #(
  parameter int ADDR_W = 7,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cls,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  input  logic              im_ack,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;

  logic [31:0]       enc_word;
  logic              enc_legal;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_cls)
      4'd0:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h20};
      4'd1:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h22};
      4'd2:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h21};
      4'd3:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h23};
      4'd4:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h2A};
      4'd5:    enc_word = {6'h0D, in_rs, in_rt, in_imm};
      4'd6:    enc_word = {6'h04, in_rs, in_rt, in_imm};
      4'd7:    enc_word = {6'h23, in_rs, in_rt, in_imm};
      4'd8:    enc_word = {6'h2B, in_rs, in_rt, in_imm};
      4'd9:    enc_word = {6'h0F, 5'h00, in_rt, in_imm};  // LUI has no rs operand
      4'd10:   enc_word = {6'h05, in_rs, in_rt, in_imm};
      4'd11:   enc_word = {6'h0A, in_rs, in_rt, in_imm};
      default: enc_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    count_d  = count_q;
    full_d   = full_q;
    err_d    = err_q;
    in_ready = 1'b0;
    im_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = !full_q;
        if (in_valid && !full_q) begin
          if (enc_legal) begin
            wdata_d = enc_word;
            state_d = ST_WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        im_we = 1'b1;
        if (im_ack) begin
          count_d = count_q + 1'b1;
          state_d = ST_IDLE;
          // The last word address is never wrapped past; full parks the encoder.
          if (addr_q == ADDR_LAST) full_d = 1'b1;
          else                     addr_d = addr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr) begin
      state_d = ST_IDLE;
      addr_d  = ADDR_BASE;
      count_d = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= ADDR_BASE;
      wdata_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign count    = count_q;
  assign full     = full_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver pushes expected IM writes, monitor pops on im_we&im_ack.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready, im_we, im_ack, full, err;
  logic [3:0]  in_cls;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [6:0]  im_addr;
  logic [31:0] im_wdata;
  logic [7:0]  count;

  logic        s_clr, s_valid, s_ready, s_we, s_ack, s_full, s_err;
  logic [3:0]  s_cls;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [15:0] s_imm;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(7), .BASE(0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_cls(in_cls), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .im_ack(im_ack),
    .count(count), .full(full), .err(err));

  instr_encoder #(.ADDR_W(2), .BASE(0)) dut_small (
    .clk(clk), .rst(rst), .clr(s_clr), .in_valid(s_valid), .in_ready(s_ready),
    .in_cls(s_cls), .in_rs(s_rs), .in_rt(s_rt), .in_rd(s_rd), .in_imm(s_imm),
    .im_we(s_we), .im_addr(s_addr), .im_wdata(s_wdata), .im_ack(s_ack),
    .count(s_count), .full(s_full), .err(s_err));

  int checks = 0;
  int errors = 0;
  logic [38:0] sb[$];   // {addr, word}
  int exp_addr = 0;
  int exp_count = 0;
  bit exp_err = 1'b0;
  bit ack_en = 1'b1;
  int ack_delay = 0;
  int wait_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference encoding from the opcode/funct tables.
  function automatic logic [31:0] model(input int cls, input int rs, input int rt, input int rd, input int imm);
    int funct[5] = '{32'h20, 32'h22, 32'h21, 32'h23, 32'h2A};
    int op[7]    = '{32'h0D, 32'h04, 32'h23, 32'h2B, 32'h0F, 32'h05, 32'h0A};
    logic [31:0] w;
    if (cls < 5) w = 32'(rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + funct[cls]);
    else w = 32'((op[cls-5] << 26) + ((cls == 9 ? 0 : rs) << 21) + (rt << 16) + imm);
    return w;
  endfunction

  initial begin : ack_drv
    im_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_en) begin
        if (im_we && !im_ack) begin
          if (wait_cnt >= ack_delay) begin
            im_ack = 1'b1;
            wait_cnt = 0;
          end else wait_cnt++;
        end else begin
          im_ack = 1'b0;
          wait_cnt = 0;
        end
      end
    end
  end

  initial begin : monitor
    logic [38:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && !clr && im_we && im_ack) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: write of %0h at %0h with no expected entry", im_wdata, im_addr);
        end else begin
          e = sb.pop_front();
          chk("im_addr", 64'(im_addr), 64'(e[38:32]));
          chk("im_wdata", 64'(im_wdata), 64'(e[31:0]));
        end
      end
    end
  end

  task automatic send(input int cls, input int rs, input int rt, input int rd, input int imm,
                      input bit use_word, input logic [31:0] word, input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout_in_ready", 64'(in_ready), 64'd1);
      return;
    end
    in_valid = 1'b1;
    in_cls = 4'(cls); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_imm = 16'(imm);
    if (cls >= 12) exp_err = 1'b1;
    else if (push) begin
      sb.push_back({7'(exp_addr), use_word ? word : model(cls, rs, rt, rd, imm)});
      exp_addr++;
      exp_count++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_cls = 4'($urandom_range(0, 15)); in_rs = 5'($urandom); in_rt = 5'($urandom);
    in_rd = 5'($urandom); in_imm = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((im_we || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    #3;
    chk("wait_idle_timeout", 64'(im_we), 64'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
    in_cls = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    s_clr = 1'b0; s_valid = 1'b0; s_ack = 1'b0;
    s_cls = '0; s_rs = '0; s_rt = '0; s_rd = '0; s_imm = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_im_we", 64'(im_we), 64'd0);
    chk("rst_im_addr", 64'(im_addr), 64'd0);
    chk("rst_im_wdata", 64'(im_wdata), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // T1
    ack_delay = 0;
    send(0, 1, 2, 3, 16'hABCD, 1, 32'h00221820, 1);
    wait_idle();
    chk("t1_count", 64'(count), 64'd1);

    // T2
    send(5, 0, 8, 17, 16'h00FF, 1, 32'h340800FF, 1);
    send(7, 29, 9, 5, 16'hFFFC, 1, 32'h8FA9FFFC, 1);
    wait_idle();

    // T3
    ack_delay = 5;
    send(6, 1, 2, 0, 3, 1, 32'h10220003, 1);
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("t3_im_we_held", 64'(im_we), 64'd1);
      chk("t3_in_ready_low", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    wait_idle();
    ack_delay = 0;

    // T4
    send(14, 3, 3, 3, 3, 0, 32'h0, 0);
    #3;
    chk("t4_no_we", 64'(im_we), 64'd0);
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_addr", 64'(im_addr), 64'(exp_addr));
    @(negedge clk);
    #3;
    chk("t4_err_sticky", 64'(err), 64'd1);
    send(4, 4, 5, 6, 16'h1234, 1, 32'h0085302A, 1);
    wait_idle();
    chk("t4_count", 64'(count), 64'(exp_count));

    // Randomized traffic including illegal classes and varying ack latency
    for (int i = 0; i < 60; i++) begin
      ack_delay = $urandom_range(0, 3);
      send($urandom_range(0, 13), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 65535), 0, 32'h0, 1);
    end
    wait_idle();
    chk("rand_count", 64'(count), 64'(exp_count));
    chk("rand_err", 64'(err), 64'(exp_err));
    chk("rand_addr", 64'(im_addr), 64'(exp_addr));
    chk("rand_sb_empty", 64'(sb.size()), 64'd0);

    // T6: clr in WRITE together with ack discards the pending word
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_addr = 0; exp_count = 0; exp_err = 1'b0;
    #3;
    chk("clr_err", 64'(err), 64'd0);
    chk("clr_count", 64'(count), 64'd0);
    ack_en = 1'b0;
    send(1, 7, 8, 9, 0, 0, 32'h0, 0);
    #3;
    chk("t6_we_before", 64'(im_we), 64'd1);
    clr = 1'b1; im_ack = 1'b1;
    @(negedge clk);
    clr = 1'b0; im_ack = 1'b0;
    #3;
    chk("t6_we_dropped", 64'(im_we), 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_addr", 64'(im_addr), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    ack_en = 1'b1;
    send(2, 1, 1, 1, 0, 0, 32'h0, 1);
    wait_idle();
    chk("t6_after_count", 64'(count), 64'd1);
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);

    // T5: 4-word memory fills and parks
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #3;
      chk("t5_ready", 64'(s_ready), 64'd1);
      s_valid = 1'b1; s_cls = 4'd0; s_rs = 5'(i); s_rt = 5'd1; s_rd = 5'd2;
      @(negedge clk);
      s_valid = 1'b0;
      #3;
      chk("t5_we", 64'(s_we), 64'd1);
      chk("t5_addr", 64'(s_addr), 64'(i));
      chk("t5_wdata", 64'(s_wdata), 64'(model(0, i, 1, 2, 0)));
      s_ack = 1'b1;
      @(negedge clk);
      s_ack = 1'b0;
    end
    #3;
    chk("t5_full", 64'(s_full), 64'd1);
    chk("t5_count", 64'(s_count), 64'd4);
    chk("t5_addr_hold", 64'(s_addr), 64'd3);
    chk("t5_ready_low", 64'(s_ready), 64'd0);
    s_valid = 1'b1; s_cls = 4'd5;
    @(negedge clk);
    s_valid = 1'b0;
    #3;
    chk("t5_no_write_when_full", 64'(s_we), 64'd0);
    chk("t5_count_hold", 64'(s_count), 64'd4);
    s_clr = 1'b1;
    @(negedge clk);
    s_clr = 1'b0;
    #3;
    chk("t5_clr_addr", 64'(s_addr), 64'd0);
    chk("t5_clr_full", 64'(s_full), 64'd0);
    chk("t5_clr_ready", 64'(s_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
